// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, FSM states and the operand-magnitude helper for the MIPS HI/LO multiply/divide unit.
package muldiv_unit_pkg;

   typedef enum logic [2:0] {
      MD_op_mult  = 3'd0,
      MD_op_multu = 3'd1,
      MD_op_div   = 3'd2,
      MD_op_divu  = 3'd3,
      MD_op_mthi  = 3'd4,
      MD_op_mtlo  = 3'd5,
      MD_op_madd  = 3'd6,
      MD_op_msub  = 3'd7
   } md_op_e;

   // MADDU shares the MADD code; signedness of 6/7 comes from decode.
   localparam logic [2:0] MD_op_maddu = 3'd6;

   typedef enum logic [1:0] {
      MD_st_idle  = 2'd0,
      MD_st_calc  = 2'd1,
      MD_st_fixup = 2'd2
   } md_st_e;

   function automatic logic [31:0] md_mag(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring divide step.
module muldiv_step import muldiv_unit_pkg::*; #(
   parameter int XLEN = 32
) (
   input  logic            is_div_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic [XLEN-1:0] m_i,
   output logic [XLEN-1:0] a_o,
   output logic [XLEN-1:0] b_o
);

   logic [XLEN:0] sum_s;
   logic [XLEN:0] shifted_s;
   logic [XLEN:0] trial_s;
   logic          ge_s;

   // Multiply shifts {acc,multiplier} right; divide shifts {rem,quotient} left.
   always_comb begin
      sum_s     = {1'b0, a_i} + {1'b0, m_i};
      shifted_s = {a_i, b_i[XLEN-1]};
      trial_s   = shifted_s - {1'b0, m_i};
      // A set top bit of the shifted remainder already exceeds any divisor.
      ge_s      = shifted_s[XLEN] | ~trial_s[XLEN];
      a_o       = a_i;
      b_o       = b_i;
      if (is_div_i) begin
         if (ge_s) begin
            a_o = trial_s[XLEN-1:0];
            b_o = {b_i[XLEN-2:0], 1'b1};
         end else begin
            a_o = shifted_s[XLEN-1:0];
            b_o = {b_i[XLEN-2:0], 1'b0};
         end
      end else if (b_i[0]) begin
         a_o = sum_s[XLEN:1];
         b_o = {sum_s[0], b_i[XLEN-1:1]};
      end else begin
         a_o = {1'b0, a_i[XLEN-1:1]};
         b_o = {a_i[0], b_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO; 32 CALC cycles plus one FIXUP cycle.
// Define MULDIV_MADD_EN to add MADD/MADDU/MSUB accumulation into {hi,lo}.
module muldiv_unit import muldiv_unit_pkg::*; #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
`ifdef MULDIV_MADD_EN
   , parameter bit MADD_SIGNED = 1'b1
`endif
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      MDOp,
   input  logic [XLEN-1:0] dInA,
   input  logic [XLEN-1:0] dInB,
   input  logic            abort,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   md_st_e            st_q;
   md_op_e            op_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [XLEN-1:0]   a_q, b_q, m_q, hi_q, lo_q;
   logic              neg_res_q, neg_rem_q, dz_q, busy_q, done_q;
   logic [XLEN-1:0]   a_nxt_s, b_nxt_s, hi_d, lo_d;
   logic              is_mul_s, is_div_s, is_sgn_s;
   logic [2*XLEN-1:0] prod_s;

   muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div_i (op_q == MD_op_div || op_q == MD_op_divu),
      .a_i      (a_q),
      .b_i      (b_q),
      .m_i      (m_q),
      .a_o      (a_nxt_s),
      .b_o      (b_nxt_s)
   );

   // Decode the incoming op into class and signedness.
   always_comb begin
      is_mul_s = (MDOp == MD_op_mult) || (MDOp == MD_op_multu);
      is_div_s = (MDOp == MD_op_div) || (MDOp == MD_op_divu);
      is_sgn_s = (MDOp == MD_op_mult) || (MDOp == MD_op_div);
`ifdef MULDIV_MADD_EN
      if ((MDOp == MD_op_madd) || (MDOp == MD_op_msub)) begin
         is_mul_s = 1'b1;
         is_sgn_s = MADD_SIGNED;
      end else begin
         is_mul_s = is_mul_s;
      end
`endif
   end

   // Sign-correct the raw result and pick what FIXUP writes into HI/LO.
   always_comb begin
      prod_s = neg_res_q ? ((2*XLEN)'(0) - {a_q, b_q}) : {a_q, b_q};
      hi_d   = hi_q;
      lo_d   = lo_q;
      case (op_q)
         MD_op_mult, MD_op_multu: {hi_d, lo_d} = prod_s;
         MD_op_div, MD_op_divu: begin
            hi_d = neg_rem_q ? (XLEN'(0) - a_q) : a_q;
            lo_d = dz_q ? '1 : (neg_res_q ? (XLEN'(0) - b_q) : b_q);
         end
`ifdef MULDIV_MADD_EN
         MD_op_madd: {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
         MD_op_msub: {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
`endif
         default: begin
            hi_d = hi_q;
            lo_d = lo_q;
         end
      endcase
   end

   // Control FSM with registered status and HI/LO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= MD_st_idle;
         op_q      <= MD_op_mult;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         m_q       <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else if (abort) begin
         st_q   <= MD_st_idle;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (st_q)
            MD_st_idle: begin
               done_q <= 1'b0;
               if (start && (is_mul_s || is_div_s)) begin
                  st_q      <= MD_st_calc;
                  busy_q    <= 1'b1;
                  op_q      <= md_op_e'(MDOp);
                  cnt_q     <= CNT_W'(XLEN - 1);
                  a_q       <= '0;
                  b_q       <= is_div_s ? md_mag(dInA, is_sgn_s) : md_mag(dInB, is_sgn_s);
                  m_q       <= is_div_s ? md_mag(dInB, is_sgn_s) : md_mag(dInA, is_sgn_s);
                  neg_res_q <= is_sgn_s & (dInA[XLEN-1] ^ dInB[XLEN-1]);
                  neg_rem_q <= is_sgn_s & dInA[XLEN-1];
                  dz_q      <= is_div_s && (dInB == '0);
               end else if (start && (MDOp == MD_op_mthi)) begin
                  hi_q <= dInA;
               end else if (start && (MDOp == MD_op_mtlo)) begin
                  lo_q <= dInA;
               end
            end
            MD_st_calc: begin
               a_q   <= a_nxt_s;
               b_q   <= b_nxt_s;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == '0) st_q <= MD_st_fixup;
            end
            MD_st_fixup: begin
               hi_q   <= hi_d;
               lo_q   <= lo_d;
               done_q <= 1'b1;
               busy_q <= 1'b0;
               st_q   <= MD_st_idle;
            end
            default: begin
               st_q   <= MD_st_idle;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit that owns the HI/LO register pair for the MIPS pipeline's MULT/MULTU/DIV/DIVU/MTHI/MTLO instructions.
- Sits beside the EX-stage ALU and takes operands from the forwarding muxes.
- Sequences a 32-step shift-add multiply or restoring divide, then a sign-fixup cycle.
- Exports `busy` so hazard logic stalls MFHI/MFLO and any new mul/div op until the result is written.

Parameters:
- XLEN, 32, operand width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe; accepted only when busy=0.
- MDOp  in  3  operation code (`MD_op_*`), sampled with start.
- dInA  in  32  rs operand (multiplicand / dividend / MT data).
- dInB  in  32  rt operand (multiplier / divisor).
- abort  in  1  pipeline flush; cancels any in-flight operation.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO are updated by a mul/div.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, all internal operand registers 0.
- State machine:
  - IDLE, CALC, FIXUP.
  - IDLE → CALC on start with a MULT/MULTU/DIV/DIVU op.
  - CALC lasts exactly 32 cycles (counter 31→0), then → FIXUP.
  - FIXUP lasts 1 cycle, writes hi/lo, then → IDLE.
- Latency: start accepted in cycle N; busy=1 in cycles N+1..N+33; new hi/lo visible, done=1 and busy=0 in cycle N+34.
- MTHI/MTLO: when start=1 and busy=0, hi (or lo) ← dInA at the clock edge. No busy, no done.
- start while busy=1: ignored entirely, including MT ops.
- Signed ops: operands converted to magnitudes at acceptance; signs are registered.
  - Multiply: product negated in FIXUP if the signs differ.
  - Divide: quotient negated if the signs differ; remainder takes the dividend's sign.
- Unsigned ops: no fixup; FIXUP is still spent so latency is op-independent.
- Multiply: 64-bit {acc, multiplier} shift-add, one bit per CALC cycle. Result hi=product[63:32], lo=product[31:0].
- Divide: restoring; one quotient bit per cycle, using a 33-bit trial subtraction. Result lo=quotient, hi=remainder.
- Divide by zero (dInB==0 at acceptance):
  - Still takes the full 34 cycles.
  - Result lo=32'hFFFFFFFF, hi=dInA, regardless of signedness.
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- abort=1 in any state: next state=IDLE, busy=0, done=0, hi/lo unchanged. abort has priority over start in the same cycle.
- abort in FIXUP: hi/lo are not written.
- Undefined MDOp with start: ignored, stays IDLE.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined: adds the ops `MD_op_madd`, `MD_op_maddu` and `MD_op_msub`.
  - Multiply proceeds as normal.
  - In FIXUP, {hi,lo} ← {hi,lo} ± signed/unsigned product, 64-bit wraparound.
  - Latency is unchanged.
  - An abort before FIXUP leaves the accumulator untouched.
- Undefined: these op codes are treated as undefined (ignored). No accumulator adder is synthesised.

Decomposition:
- The shared declarations header holds the op macros: `MD_op_mult`=0, `MD_op_multu`=1, `MD_op_div`=2, `MD_op_divu`=3, `MD_op_mthi`=4, `MD_op_mtlo`=5, `MD_op_madd`=6, `MD_op_msub`=7.
- `MD_op_maddu` is encoded as 3'b110 with a separate signed bit derived in decode; the ops 6/7 pair with the unsigned flag.
- The same header holds the state encodings `MD_st_idle`/`MD_st_calc`/`MD_st_fixup`.
- One natural sub-module: muldiv_step. It is a combinational single-iteration datapath (conditional add for multiply, trial subtract for divide) driven by the FSM in muldiv_unit.

Test Plan:
- MULT dInA=32'hFFFFFFFF, dInB=2 → at N+34 hi=32'hFFFFFFFF, lo=32'hFFFFFFFE, done pulse 1 cycle; MULTU with the same operands → hi=1, lo=32'hFFFFFFFE.
- DIV dInA=-7 (32'hFFFFFFF9), dInB=2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU 100/7 → lo=14, hi=2.
- DIVU dInA=32'h12345678, dInB=0 → after 34 cycles lo=32'hFFFFFFFF, hi=32'h12345678.
- MULT 3×5 accepted; at N+10 assert start with MTHI 32'hAAAA → ignored; busy stays 1 through N+33; hi=0, lo=15 at N+34.
- Start DIV 50/5, abort at N+10 → busy=0 at N+11, no done, hi/lo keep prior values; immediately restart MULT 6×7 → lo=42 after 34 cycles.
- Assert rst_n=0 mid-CALC → outputs zero asynchronously. With MULDIV_MADD_EN: MTLO 10, then MADD 4×5 → lo=30, hi=0; MSUB 8×5 → lo=32'hFFFFFFF6, hi=32'hFFFFFFFF.
